crc16_frame_appender: RTL

- Transmit-side framing stage that accepts a byte-wide payload stream with a valid/ready handshake and an end-of-frame marker.
- Forwards each payload byte unchanged and keeps a running byte-parallel CRC-16 over the frame.
- After the last payload byte, appends the two CRC bytes, MSB first, then re-arms for the next frame.
- Sits between the packet source and the serializer, as the generator-side counterpart of the CRC_16_parallel checker.

---
 rtl/crc16_pkg.sv | 30 +++
 rtl/crc16_byte_engine.sv | 42 ++++
 rtl/crc16_frame_appender.sv | 111 +++++++++++
 3 files changed

// File: rtl/crc16_pkg.sv
// rtl/crc16_pkg.sv - shared CRC-16 constants, FSM state type and byte update function
package crc16_pkg;

    localparam logic [15:0] CRC16_POLY_DEFAULT = 16'h8005;
    localparam logic [15:0] CRC16_INIT_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CRC_HI,
        CRC_LO
    } crc_app_state_t;

    // Eight MSB-first shift steps of a non-reflected CRC-16, one data bit per step.
    function automatic logic [15:0] crc16_byte_update(
        input logic [15:0] crc,
        input logic [7:0]  data,
        input logic [15:0] poly
    );
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[15] ^ data[7-i];
            c  = {c[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_byte_engine.sv
// rtl/crc16_byte_engine.sv - byte-parallel CRC-16 register with seed and enable
module crc16_byte_engine
    import crc16_pkg::*;
#(
    parameter logic [15:0] POLY = CRC16_POLY_DEFAULT,
    parameter logic [15:0] INIT = CRC16_INIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_i,
    input  logic        enable_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic [15:0] base;

    // seed_i restarts from INIT; with enable_i the byte is folded onto the fresh seed.
    always_comb begin
        base  = seed_i ? INIT : crc_q;
        crc_d = crc_q;
        if (enable_i) begin
            crc_d = crc16_byte_update(base, data_i, POLY);
        end else if (seed_i) begin
            crc_d = INIT;
        end
    end

    // Running CRC state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/crc16_frame_appender.sv
// rtl/crc16_frame_appender.sv - forwards payload bytes and appends CRC-16 MSB first
module crc16_frame_appender
    import crc16_pkg::*;
#(
    parameter logic [15:0] POLY    = CRC16_POLY_DEFAULT,
    parameter logic [15:0] INIT    = CRC16_INIT_DEFAULT,
    parameter logic [15:0] XOR_OUT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    output logic        out_is_crc,
    input  logic        out_ready,
    output logic [15:0] crc_value
);

    crc_app_state_t state_q;
    logic           armed_q;
    logic [7:0]     out_data_q;
    logic           out_valid_q;
    logic           out_last_q;
    logic           out_is_crc_q;
    logic [15:0]    crc_value_q;

    logic           slot_free;
    logic           accept;
    logic           seed;
    logic [15:0]    crc_reg;
    logic [15:0]    crc_final;

    // armed_q keeps in_ready low while reset is applied and releases it one edge later.
    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = armed_q && ((state_q == IDLE) || (state_q == PAYLOAD)) && slot_free;
    assign accept    = in_valid && in_ready;
    assign seed      = (state_q == IDLE) || ((state_q == CRC_LO) && slot_free);
    assign crc_final = crc_reg ^ XOR_OUT;

    crc16_byte_engine #(
        .POLY (POLY),
        .INIT (INIT)
    ) u_engine (
        .clk      (clk),
        .rst      (rst),
        .seed_i   (seed),
        .enable_i (accept),
        .data_i   (in_data),
        .crc_o    (crc_reg)
    );

    // Frame sequencing and the single registered output slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            armed_q      <= 1'b0;
            out_data_q   <= 8'h00;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_is_crc_q <= 1'b0;
            crc_value_q  <= 16'h0000;
        end else begin
            armed_q <= 1'b1;
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE, PAYLOAD: begin
                    if (accept) begin
                        out_data_q   <= in_data;
                        out_valid_q  <= 1'b1;
                        out_last_q   <= 1'b0;
                        out_is_crc_q <= 1'b0;
                        state_q      <= in_last ? CRC_HI : PAYLOAD;
                    end
                end
                CRC_HI: begin
                    if (slot_free) begin
                        out_data_q   <= crc_final[15:8];
                        out_valid_q  <= 1'b1;
                        out_last_q   <= 1'b0;
                        out_is_crc_q <= 1'b1;
                        state_q      <= CRC_LO;
                    end
                end
                CRC_LO: begin
                    if (slot_free) begin
                        out_data_q   <= crc_final[7:0];
                        out_valid_q  <= 1'b1;
                        out_last_q   <= 1'b1;
                        out_is_crc_q <= 1'b1;
                        crc_value_q  <= crc_final;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_is_crc = out_is_crc_q;
    assign crc_value  = crc_value_q;

endmodule
